// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared widths, entry record and wrap-aware age compare for the issue queue.
package issue_queue_pkg;
    localparam int PHYS_W = 6;
    localparam int CTR_W = 32;
    localparam int PAYLOAD_W = 96;

    typedef struct packed {
        logic valid;
        logic uses_rs;
        logic uses_rt;
        logic uses_rw;
        logic [PHYS_W-1:0] rs_phys;
        logic [PHYS_W-1:0] rt_phys;
        logic [PHYS_W-1:0] rw_phys;
        logic rs_rdy;
        logic rt_rdy;
        logic [CTR_W-1:0] count;
        logic [PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    // a is older than b when b - a is a nonzero non-negative distance modulo 2^CTR_W
    function automatic logic is_older(logic [CTR_W-1:0] a, logic [CTR_W-1:0] b);
        logic [CTR_W-1:0] d;
        d = b - a;
        return !d[CTR_W-1] && (d != '0);
    endfunction
endpackage

// File: rtl/issue_queue_if.sv
// issue_queue_if: dispatch, wakeup, issue and kill signals between rename, writeback, execute and the issue queue.
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NUM_WB = 2
);
    logic in_valid;
    logic in_ready;
    logic in_uses_rs;
    logic in_uses_rt;
    logic in_uses_rw;
    logic [PHYS_W-1:0] in_rs_phys;
    logic [PHYS_W-1:0] in_rt_phys;
    logic [PHYS_W-1:0] in_rw_phys;
    logic in_rs_rdy;
    logic in_rt_rdy;
    logic [CTR_W-1:0] in_count;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [NUM_WB-1:0] wb_valid;
    logic [NUM_WB-1:0][PHYS_W-1:0] wb_tag;
    logic issue_valid;
    logic issue_ready;
    logic [PHYS_W-1:0] issue_rs_phys;
    logic [PHYS_W-1:0] issue_rt_phys;
    logic [PHYS_W-1:0] issue_rw_phys;
    logic issue_uses_rw;
    logic [CTR_W-1:0] issue_count;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic squash_valid;
    logic [CTR_W-1:0] squash_count;
    logic flush;
    logic [$clog2(DEPTH):0] occupancy;

    modport master (
        output in_valid, in_uses_rs, in_uses_rt, in_uses_rw, in_rs_phys, in_rt_phys, in_rw_phys,
               in_rs_rdy, in_rt_rdy, in_count, in_payload, wb_valid, wb_tag, issue_ready,
               squash_valid, squash_count, flush,
        input  in_ready, issue_valid, issue_rs_phys, issue_rt_phys, issue_rw_phys, issue_uses_rw,
               issue_count, issue_payload, occupancy
    );

    modport slave (
        input  in_valid, in_uses_rs, in_uses_rt, in_uses_rw, in_rs_phys, in_rt_phys, in_rw_phys,
               in_rs_rdy, in_rt_rdy, in_count, in_payload, wb_valid, wb_tag, issue_ready,
               squash_valid, squash_count, flush,
        output in_ready, issue_valid, issue_rs_phys, issue_rt_phys, issue_rw_phys, issue_uses_rw,
               issue_count, issue_payload, occupancy
    );
endinterface

// File: rtl/issue_queue_age.sv
// iq_age_select: binary-tree reduction picking the oldest ready entry; the left (lower index) child wins ties.
module iq_age_select
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0] ready,
    input  logic [CTR_W-1:0] count [DEPTH],
    output logic [$clog2(DEPTH)-1:0] grant,
    output logic grant_valid
);
    localparam int LG = $clog2(DEPTH);

    for (genvar l = 0; l <= LG; l++) begin : lv
        localparam int N = DEPTH >> l;
        logic v [N];
        logic [LG-1:0] ix [N];
        logic [CTR_W-1:0] c [N];
        for (genvar i = 0; i < N; i++) begin : n
            if (l == 0) begin : leaf
                assign v[i] = ready[i];
                assign ix[i] = LG'(i);
                assign c[i] = count[i];
            end else begin : node
                logic r;
                assign r = lv[l-1].v[2*i+1] &&
                           (!lv[l-1].v[2*i] || is_older(lv[l-1].c[2*i+1], lv[l-1].c[2*i]));
                assign v[i] = lv[l-1].v[2*i] || lv[l-1].v[2*i+1];
                assign ix[i] = r ? lv[l-1].ix[2*i+1] : lv[l-1].ix[2*i];
                assign c[i] = r ? lv[l-1].c[2*i+1] : lv[l-1].c[2*i];
            end
        end
    end

    assign grant = lv[LG].ix[0];
    assign grant_valid = lv[LG].v[0];
endmodule

// File: rtl/issue_queue.sv
// issue_queue: out-of-order issue buffer with writeback wakeup, oldest-ready select, squash and flush.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NUM_WB = 2
) (
    input logic clk,
    input logic rst_n,
    issue_queue_if.slave q
);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t e [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [CTR_W-1:0] cnt [DEPTH];
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] free_idx;
    logic grant_valid;
    logic alloc;
    logic fire;
    logic [IDX_W:0] occ;

    function automatic logic woke(logic [PHYS_W-1:0] tag, logic [NUM_WB-1:0] v,
                                  logic [NUM_WB-1:0][PHYS_W-1:0] t);
        woke = 1'b0;
        for (int k = 0; k < NUM_WB; k++) woke |= v[k] && t[k] == tag;
    endfunction

    always_comb begin
        occ = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            occ = occ + (IDX_W+1)'(e[i].valid);
            if (!e[i].valid) free_idx = IDX_W'(i);
        end
    end

    assign q.in_ready = (occ < (IDX_W+1)'(DEPTH)) && !q.flush;
    assign alloc = q.in_valid && q.in_ready;
    assign fire = grant_valid && q.issue_ready;
    assign q.occupancy = occ;

    iq_age_select #(.DEPTH(DEPTH)) u_sel (
        .ready(rdy),
        .count(cnt),
        .grant(grant),
        .grant_valid(grant_valid)
    );

    assign q.issue_valid = grant_valid;
    assign q.issue_rs_phys = e[grant].rs_phys;
    assign q.issue_rt_phys = e[grant].rt_phys;
    assign q.issue_rw_phys = e[grant].rw_phys;
    assign q.issue_uses_rw = e[grant].uses_rw;
    assign q.issue_count = e[grant].count;
    assign q.issue_payload = e[grant].payload;

    for (genvar i = 0; i < DEPTH; i++) begin : g
        iq_entry_t r;
        assign e[i] = r;
        assign rdy[i] = r.valid && (!r.uses_rs || r.rs_rdy) && (!r.uses_rt || r.rt_rdy);
        assign cnt[i] = r.count;

        // flush beats everything; the free slot being written can never be the granted one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r <= '0;
            end else if (q.flush) begin
                r.valid <= 1'b0;
            end else if (alloc && free_idx == IDX_W'(i)) begin
                r <= '{valid:   !(q.squash_valid && is_older(q.squash_count, q.in_count)),
                       uses_rs: q.in_uses_rs,
                       uses_rt: q.in_uses_rt,
                       uses_rw: q.in_uses_rw,
                       rs_phys: q.in_rs_phys,
                       rt_phys: q.in_rt_phys,
                       rw_phys: q.in_rw_phys,
                       rs_rdy:  q.in_rs_rdy || woke(q.in_rs_phys, q.wb_valid, q.wb_tag),
                       rt_rdy:  q.in_rt_rdy || woke(q.in_rt_phys, q.wb_valid, q.wb_tag),
                       count:   q.in_count,
                       payload: q.in_payload};
            end else begin
                if (r.uses_rs && woke(r.rs_phys, q.wb_valid, q.wb_tag)) r.rs_rdy <= 1'b1;
                if (r.uses_rt && woke(r.rt_phys, q.wb_valid, q.wb_tag)) r.rt_rdy <= 1'b1;
                if ((fire && grant == IDX_W'(i)) ||
                    (q.squash_valid && is_older(q.squash_count, r.count)))
                    r.valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Out-of-order issue buffer fed by register_renaming. It accepts renamed instructions tagged with physical source and destination registers and an age counter.
- It tracks operand readiness through writeback wakeups and issues the oldest ready entry to execute.
- It discards wrong-path entries on a branch mispredict (squash) or a full pipeline flush.

Parameters:
DEPTH, 16, number of entries (power of 2, 2..32)
PHYS_W, 6, physical register tag width (64 physical registers)
CTR_W, 32, age counter width, matches the rename instruction counter
PAYLOAD_W, 96, opaque payload width: alu_ctl, immediate, branch/mem fields, carried unchanged
NUM_WB, 2, writeback wakeup ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  renamed instruction offered
in_ready  out  1  queue can accept (occupancy < DEPTH and not flush)
in_uses_rs / in_uses_rt / in_uses_rw  in  1 each  operand/dest used
in_rs_phys / in_rt_phys / in_rw_phys  in  PHYS_W each  physical tags
in_rs_rdy / in_rt_rdy  in  1 each  operand already available at rename
in_count  in  CTR_W  age tag, monotonically increasing, wraps
in_payload  in  PAYLOAD_W  pass-through fields
wb_valid  in  NUM_WB  wakeup strobes
wb_tag  in  NUM_WB*PHYS_W  physical registers written this cycle
issue_valid  out  1  selected entry present
issue_ready  in  1  execute accepts
issue_rs_phys / issue_rt_phys / issue_rw_phys  out  PHYS_W each  tags of issued entry
issue_uses_rw  out  1  dest used
issue_count  out  CTR_W  age of issued entry
issue_payload  out  PAYLOAD_W  payload of issued entry
squash_valid  in  1  mispredict resolved
squash_count  in  CTR_W  age of the mispredicted branch
flush  in  1  kill every entry
occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (async, rst_n=0): all entry valid bits 0, occupancy 0, issue_valid 0, in_ready 1. Reset during operation drops all entries immediately.
- Allocation: in_valid && in_ready writes the lowest-index free slot at the clock edge. The entry is selectable the next cycle (minimum rename-to-issue latency is 1 cycle).
- Operand ready = !uses_x || rdy_x.
- Same-cycle wakeup bypass: if an incoming tag matches any active wb_tag, its rdy bit is stored as 1.
- Wakeup: every valid entry with uses_x && tag == wb_tag[k] && wb_valid[k] sets rdy_x at the edge. Multiple ports may match the same entry; the result is OR-ed.
- Select (combinational): among valid entries with both operands ready, pick the oldest.
  - A is older than B iff the MSB of (B.count - A.count) is 0 and the difference is nonzero. This is modulo 2^CTR_W, so it stays correct across wrap.
  - Ties are impossible because counts are unique; the lowest index wins as a guard.
  - issue_* outputs are driven from the selected entry; issue_valid = any ready entry.
- Issue handshake: on issue_valid && issue_ready the selected entry is freed at the edge. Outputs may change while issue_ready=0; no hold requirement.
- Full: in_ready = (occupancy < DEPTH) && !flush. A free and an alloc in the same cycle do not grant extra credit.
- Squash: squash_valid invalidates every entry younger than squash_count (same wrap-aware compare). The branch itself and older entries survive.
  - If squash_valid and an alloc occur in the same cycle, the incoming entry is also subject to the squash compare.
  - An entry issued in the same cycle as the squash is freed regardless.
- Flush: clears all valid bits at the edge. It overrides alloc, issue, wakeup and squash.
- Occupancy updates by +alloc -issue -squashed. It is recomputed as the popcount of the valid bits; no separate counter may drift.
- A wakeup tag of a non-matching or invalid entry has no effect. wb_valid=0 ports are ignored.

Decomposition:
- Shared package (mips_core_pkg or issue_queue_pkg):
  - iq_entry_t struct: valid, uses_rs/rt/rw, rs/rt/rw_phys, rs_rdy, rt_rdy, count, payload.
  - The age-compare function is_older(a,b).
- One sub-module: iq_age_select. It takes the ready vector and count array and outputs grant index and grant valid. It uses a tree reduction so it can be verified standalone.

Test Plan:
- Reset, then one entry with rs_rdy=rt_rdy=1, count=5, issue_ready=1 -> issue_valid=1 the next cycle, issue_count=5, occupancy returns to 0.
- Entry rs_phys=40 not ready; wb_valid[0]=1, wb_tag=40 two cycles later -> issue_valid rises the cycle after wakeup. A simultaneous alloc with rs_phys=40 gets rdy via bypass and issues next.
- Three ready entries with counts 0xFFFFFFFE, 0xFFFFFFFF, 0x00000001 -> issued in that order across wrap.
- Fill 16 entries with issue_ready=0 -> in_ready=0 and occupancy=16. A 17th in_valid is not accepted; one issue -> in_ready=1 the following cycle.
- Entries with counts 10..14, squash_valid with squash_count=11 -> entries 12..14 removed, 10 and 11 remain, occupancy=2.
- flush asserted with in_valid=1 and pending wakeups -> all valid 0 next cycle, incoming entry dropped. rst_n pulsed low mid-fill -> occupancy=0 immediately, issue_valid=0.
